// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache sequencer.
// One fetch in flight, single-word refills, whole-cache flush, hit/miss stats.
module icache_ctrl #(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rsp_data,
   output logic              cpu_rsp_hit,
   output logic              cpu_rsp_err,
   input  logic              flush,
   output logic              flush_busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   input  logic              mem_rsp_err,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOOKUP    = 3'd1;
   localparam logic [2:0] S_MISS_REQ  = 3'd2;
   localparam logic [2:0] S_MISS_WAIT = 3'd3;
   localparam logic [2:0] S_FLUSH     = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [INDEX_BITS-1:0] fidx_q, fidx_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_hit_q, rsp_hit_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [DATA_W-1:0]     data_mem [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  lookup_hit;
   logic                  fill_we;

   assign idx        = addr_q[INDEX_BITS-1:0];
   assign tag        = addr_q[ADDR_W-1:INDEX_BITS];
   assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

   // Next-state, response and counter logic for the fetch/flush sequencer.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      valid_d      = valid_q;
      fidx_d       = fidx_q;
      rsp_valid_d  = 1'b0;
      rsp_hit_d    = rsp_hit_q;
      rsp_err_d    = rsp_err_q;
      rsp_data_d   = rsp_data_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      fill_we      = 1'b0;
      // A flush seen mid-access is remembered until the access retires.
      flush_pend_d = flush_pend_q | (flush && (state_q != S_IDLE));
      unique case (state_q)
         S_IDLE: begin
            if (flush || flush_pend_q) begin
               state_d = S_FLUSH;
               fidx_d  = '0;
            end else if (cpu_req_valid) begin
               addr_d  = cpu_req_addr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (lookup_hit) begin
               rsp_valid_d = 1'b1;
               rsp_hit_d   = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = data_mem[idx];
               hit_cnt_d   = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
               state_d     = S_IDLE;
            end else begin
               state_d = S_MISS_REQ;
            end
         end
         S_MISS_REQ: begin
            if (mem_req_ready) state_d = S_MISS_WAIT;
         end
         S_MISS_WAIT: begin
            if (mem_rsp_valid) begin
               rsp_valid_d = 1'b1;
               rsp_hit_d   = 1'b0;
               rsp_err_d   = mem_rsp_err;
               rsp_data_d  = mem_rsp_err ? '0 : mem_rsp_data;
               fill_we     = ~mem_rsp_err;
               if (!mem_rsp_err) valid_d[idx] = 1'b1;
               miss_cnt_d  = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_FLUSH: begin
            valid_d[fidx_q] = 1'b0;
            fidx_d          = fidx_q + 1'b1;
            if (&fidx_q) begin
               flush_pend_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, valid bits, response and statistics registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         fidx_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_hit_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
         fidx_q       <= fidx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_hit_q    <= rsp_hit_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Tag and data arrays; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= mem_rsp_data;
      end
   end

   assign cpu_req_ready = (state_q == S_IDLE) && !flush && !flush_pend_q;
   assign cpu_rsp_valid = rsp_valid_q;
   assign cpu_rsp_data  = rsp_data_q;
   assign cpu_rsp_hit   = rsp_hit_q;
   assign cpu_rsp_err   = rsp_err_q;
   assign flush_busy    = flush_pend_q || (state_q == S_FLUSH);
   assign mem_req_valid = (state_q == S_MISS_REQ);
   assign mem_req_addr  = addr_q;
   assign hit_count     = hit_cnt_q;
   assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed bench with a line-level cache model and
// a per-cycle response/counter checker.
module tb_icache_ctrl;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          reset_n;
   logic          cpu_req_valid;
   logic          cpu_req_ready;
   logic [31:0]   cpu_req_addr;
   logic          cpu_rsp_valid;
   logic [31:0]   cpu_rsp_data;
   logic          cpu_rsp_hit;
   logic          cpu_rsp_err;
   logic          flush;
   logic          flush_busy;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic          mem_rsp_valid;
   logic [31:0]   mem_rsp_data;
   logic          mem_rsp_err;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   icache_ctrl #(
      .INDEX_BITS(6), .ADDR_W(32), .DATA_W(32), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_addr(cpu_req_addr), .cpu_rsp_valid(cpu_rsp_valid),
      .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_hit(cpu_rsp_hit),
      .cpu_rsp_err(cpu_rsp_err), .flush(flush), .flush_busy(flush_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct {
      logic [31:0] data;
      logic        hit;
      logic        err;
      int          edg;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          m_hits = 0;
   int          m_miss = 0;
   logic        mv    [64];
   logic [25:0] mtag  [64];
   logic [31:0] mdata [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Response and statistics checker against the model.
   always @(negedge clk) begin
      if (!reset_n) begin
         expq.delete();
         m_hits = 0;
         m_miss = 0;
      end else begin
         if (cpu_rsp_valid) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", cpu_rsp_valid, 1'b0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("rsp_data", cpu_rsp_data, e.data);
               chk("rsp_hit", cpu_rsp_hit, e.hit);
               chk("rsp_err", cpu_rsp_err, e.err);
               chk("rsp_edge", cyc, e.edg);
               if (e.hit) begin
                  if (m_hits < CMAX) m_hits++;
               end else begin
                  if (m_miss < CMAX) m_miss++;
               end
            end
         end
         chk("hit_count", hit_count, m_hits);
         chk("miss_count", miss_count, m_miss);
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 64; i++) mv[i] = 1'b0;
   endtask

   // One fetch; on a miss the bench plays the memory, optionally stalling
   // the request and pulsing flush while the refill is outstanding.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                        input logic e, input int rwait, input logic fl);
      int   idx;
      int   n;
      int   t;
      int   cnt;
      int   rdy_bad;
      logic hit;
      exp_t x;
      @(posedge clk); #1;
      t = 0;
      while (!cpu_req_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!cpu_req_ready) begin
         chk("req_ready_timeout", cpu_req_ready, 1'b1);
         return;
      end
      idx = int'(a[5:0]);
      hit = mv[idx] && (mtag[idx] == a[31:6]);
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      @(posedge clk); #1;
      n = cyc;
      cpu_req_valid = 1'b0;
      if (hit) begin
         x = '{mdata[idx], 1'b1, 1'b0, n + 1};
         expq.push_back(x);
         @(posedge clk);
         @(negedge clk);
         return;
      end
      chk("mem_req_pre", mem_req_valid, 1'b0);
      @(posedge clk); #1;
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_req_addr", mem_req_addr, a);
      for (int i = 0; i < rwait; i++) begin
         @(posedge clk); #1;
         chk("mem_req_hold", mem_req_valid, 1'b1);
         chk("mem_req_addr_hold", mem_req_addr, a);
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      chk("mem_req_drop", mem_req_valid, 1'b0);
      if (fl) begin
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         chk("flush_busy_pend", flush_busy, 1'b1);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      mem_rsp_err   = e;
      x = '{(e ? 32'h0 : d), 1'b0, e, cyc + 1};
      expq.push_back(x);
      if (!e) begin
         mv[idx]    = 1'b1;
         mtag[idx]  = a[31:6];
         mdata[idx] = d;
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_data  = 32'h0BAD_0BAD;
      if (fl) begin
         model_clear();
         chk("flush_ready_low", cpu_req_ready, 1'b0);
         cnt     = 0;
         rdy_bad = 0;
         while (flush_busy && cnt < 300) begin
            if (cpu_req_ready) rdy_bad++;
            cnt++;
            @(posedge clk); #1;
         end
         chk("flush_cycles", cnt, 65);
         chk("flush_ready_blocked", rdy_bad, 0);
         chk("flush_ready_after", cpu_req_ready, 1'b1);
      end
      @(negedge clk);
   endtask

   initial begin
      reset_n       = 1'b0;
      cpu_req_valid = 1'b0;
      cpu_req_addr  = '0;
      flush         = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_err   = 1'b0;
      model_clear();
      @(posedge clk); #1;
      chk("rst_ready", cpu_req_ready, 1'b1);
      chk("rst_rsp_valid", cpu_rsp_valid, 1'b0);
      chk("rst_rsp_data", cpu_rsp_data, 32'h0);
      chk("rst_mem_valid", mem_req_valid, 1'b0);
      chk("rst_mem_addr", mem_req_addr, 32'h0);
      chk("rst_flush_busy", flush_busy, 1'b0);
      chk("rst_hits", hit_count, 4'd0);
      chk("rst_misses", miss_count, 4'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Cold miss, then a hit on the same word.
      fetch(32'h40, 32'hDEADBEEF, 1'b0, 0, 1'b0);
      chk("cold_data", cpu_rsp_data, 32'hDEADBEEF);
      chk("cold_hit", cpu_rsp_hit, 1'b0);
      chk("cold_misses", miss_count, 4'd1);
      fetch(32'h40, 32'h0, 1'b0, 0, 1'b0);
      chk("rehit_data", cpu_rsp_data, 32'hDEADBEEF);
      chk("rehit_hit", cpu_rsp_hit, 1'b1);
      chk("rehit_hits", hit_count, 4'd1);

      // Conflict on index 0.
      fetch(32'h80, 32'h11110080, 1'b0, 0, 1'b0);
      chk("conf_80_hit", cpu_rsp_hit, 1'b0);
      fetch(32'h40, 32'h22220040, 1'b0, 2, 1'b0);
      chk("conf_40_hit", cpu_rsp_hit, 1'b0);
      chk("conf_40_data", cpu_rsp_data, 32'h22220040);
      chk("conf_misses", miss_count, 4'd3);

      // Stalled request followed by an error refill.
      fetch(32'hC5, 32'h55555555, 1'b1, 5, 1'b0);
      chk("err_flag", cpu_rsp_err, 1'b1);
      chk("err_data", cpu_rsp_data, 32'h0);
      fetch(32'hC5, 32'h12345678, 1'b0, 0, 1'b0);
      chk("err_refetch_hit", cpu_rsp_hit, 1'b0);
      chk("err_refetch_err", cpu_rsp_err, 1'b0);

      // Flush raised while a refill is outstanding.
      fetch(32'h41, 32'hA0A0A0A0, 1'b0, 0, 1'b0);
      fetch(32'h41, 32'h0, 1'b0, 0, 1'b0);
      fetch(32'h07, 32'h07070707, 1'b0, 1, 1'b1);
      fetch(32'h41, 32'hB1B1B1B1, 1'b0, 0, 1'b0);
      chk("post_flush_41", cpu_rsp_hit, 1'b0);
      fetch(32'h07, 32'hC7C7C7C7, 1'b0, 0, 1'b0);
      chk("post_flush_07", cpu_rsp_hit, 1'b0);

      // Asynchronous reset while the refill request is pending.
      @(posedge clk); #1;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 32'h2A;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      @(posedge clk); #1;
      chk("arst_in_req", mem_req_valid, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_mem_valid", mem_req_valid, 1'b0);
      chk("arst_hits", hit_count, 4'd0);
      chk("arst_misses", miss_count, 4'd0);
      chk("arst_ready", cpu_req_ready, 1'b1);
      model_clear();
      @(posedge clk); #1;
      reset_n       = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hFEEDFACE;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_stray_rsp", cpu_rsp_valid, 1'b0);
      end
      fetch(32'h2A, 32'h2A2A2A2A, 1'b0, 0, 1'b0);
      chk("arst_refetch_hit", cpu_rsp_hit, 1'b0);

      // Saturating hit counter.
      fetch(32'h33, 32'h33333333, 1'b0, 0, 1'b0);
      for (int i = 0; i < 20; i++) fetch(32'h33, 32'h0, 1'b0, 0, 1'b0);
      chk("sat_hits", hit_count, 4'd15);
      chk("sat_misses", miss_count, 4'd2);

      repeat (3) @(negedge clk);
      chk("exp_queue_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
